// File: rtl/preta_pkg.sv
// Shared types and constants for the deconv patch generator.
package preta_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TILE_N     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef logic [0:TILE_N-1][0:TILE_N-1][DATA_W_DEF-1:0] patch4_t;

endpackage

// File: rtl/preta_line_buf.sv
// One frame row of pixel storage; on each accepted pixel the old word at the
// current column is presented on dout and replaced by din at the clock edge.
module preta_line_buf
  import preta_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Read-before-write: dout is the word stored one row earlier at this column.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[addr] = din;
    dout = mem_q[addr];
  end

  // Row storage register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/preta_patch_gen.sv
// Raster pixel stream -> overlapping 4x4 patches with stride TILE_S.
// Three chained row buffers supply the rows above the incoming pixel; a 4x4
// shift window collects the last four columns of the four newest rows.
module preta_patch_gen
  import preta_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int TILE_S = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      valid_in,
  input  logic                                      sof_in,
  input  logic [DATA_W-1:0]                         pixel_in,
  output logic                                      valid_out,
  output logic [0:TILE_N-1][0:TILE_N-1][DATA_W-1:0] patch_out,
  output logic [7:0]                                tile_x,
  output logic [7:0]                                tile_y,
  output logic                                      frame_done
);

  localparam int         AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [7:0] X_MAX = 8'(IMG_W - 1);
  localparam logic [7:0] Y_MAX = 8'(IMG_H - 1);
  localparam logic [7:0] S8    = 8'(TILE_S);

  typedef logic [0:TILE_N-1][0:TILE_N-1][DATA_W-1:0] win_t;

  state_t            state_q, state_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  win_t              win_q, win_d, patch_q, patch_d;
  logic [7:0]        tx_q, tx_d, ty_q, ty_d;
  logic              vo_q, vo_d, fd_q, fd_d;
  logic              acc, sof_acc, emit, last;
  logic [7:0]        px, py;
  logic [DATA_W-1:0] row1_rd, row2_rd, row3_rd;

  // A coordinate sits on the stride grid once the window has 4 samples.
  function automatic logic on_grid(input logic [7:0] p);
    return (p >= 8'd3) && (((p - 8'd3) % S8) == 8'd0);
  endfunction

  function automatic logic [7:0] tile_idx(input logic [7:0] p);
    return (p - 8'd3) / S8;
  endfunction

  // Row y-1 buffer: new pixels in, previous row out.
  preta_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(AW)) u_row1 (
    .clk(clk), .rst_n(rst_n), .we(acc), .addr(px[AW-1:0]), .din(pixel_in), .dout(row1_rd)
  );

  // Row y-2 buffer.
  preta_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(AW)) u_row2 (
    .clk(clk), .rst_n(rst_n), .we(acc), .addr(px[AW-1:0]), .din(row1_rd), .dout(row2_rd)
  );

  // Row y-3 buffer.
  preta_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(AW)) u_row3 (
    .clk(clk), .rst_n(rst_n), .we(acc), .addr(px[AW-1:0]), .din(row2_rd), .dout(row3_rd)
  );

  // Accept/position logic, FSM next state, window shift and emit decision.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    patch_d = patch_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    vo_d    = 1'b0;
    fd_d    = 1'b0;

    sof_acc = valid_in && sof_in;
    acc     = valid_in && (sof_in || (state_q == ACTIVE));
    // A start-of-frame pixel is always (0,0), also when it aborts a frame.
    px      = sof_acc ? 8'd0 : x_q;
    py      = sof_acc ? 8'd0 : y_q;
    emit    = acc && on_grid(px) && on_grid(py);
    last    = acc && (px == X_MAX) && (py == Y_MAX);

    if (acc) begin
      for (int r = 0; r < TILE_N; r++) begin
        for (int c = 0; c < TILE_N - 1; c++) win_d[r][c] = win_q[r][c+1];
      end
      win_d[0][3] = row3_rd;
      win_d[1][3] = row2_rd;
      win_d[2][3] = row1_rd;
      win_d[3][3] = pixel_in;

      state_d = ACTIVE;
      if (px == X_MAX) begin
        x_d = 8'd0;
        y_d = py + 8'd1;
      end else begin
        x_d = px + 8'd1;
        y_d = py;
      end

      if (last) begin
        state_d = IDLE;
        x_d     = 8'd0;
        y_d     = 8'd0;
        fd_d    = 1'b1;
      end

      if (emit) begin
        vo_d    = 1'b1;
        patch_d = win_d;
        tx_d    = tile_idx(px);
        ty_d    = tile_idx(py);
      end
    end
  end

  // State, counters, window and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      patch_q <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      vo_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      patch_q <= patch_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      vo_q    <= vo_d;
      fd_q    <= fd_d;
    end
  end

  assign valid_out  = vo_q;
  assign patch_out  = patch_q;
  assign tile_x     = tx_q;
  assign tile_y     = ty_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_preta_patch_gen.sv
// Directed bench: three generators (stride 2, 1, 3) on a shared 8x8 pixel stream.
module tb_preta_patch_gen;
  import preta_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          sof_in;
  logic [DW-1:0] pixel_in;

  logic [0:3][0:3][DW-1:0] po [3];
  logic                    vo [3];
  logic                    fd [3];
  logic [7:0]              tx [3];
  logic [7:0]              ty [3];

  int n_cmp = 0;
  int n_bad = 0;
  int s_of [3] = '{2, 1, 3};
  int pulses [3];

  always #5 clk = ~clk;

  preta_patch_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(8), .TILE_S(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .valid_out(vo[0]), .patch_out(po[0]), .tile_x(tx[0]), .tile_y(ty[0]), .frame_done(fd[0])
  );
  preta_patch_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(8), .TILE_S(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .valid_out(vo[1]), .patch_out(po[1]), .tile_x(tx[1]), .tile_y(ty[1]), .frame_done(fd[1])
  );
  preta_patch_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(8), .TILE_S(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .valid_out(vo[2]), .patch_out(po[2]), .tile_x(tx[2]), .tile_y(ty[2]), .frame_done(fd[2])
  );

  function automatic logic [DW-1:0] pix(input int base, input int y, input int x);
    return DW'(base + y * 16 + x);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Feed pixels (0,0)..(stop_y,stop_x) of an 8x8 frame, sof on the first,
  // optional random idle cycles, and check every DUT after every cycle.
  task automatic run_frame(input int base, input int gap_pct, input int stop_y, input int stop_x);
    logic [0:3][0:3][DW-1:0] e;
    logic exp_emit, exp_fd;
    int x, y, s;
    for (int k = 0; k < 3; k++) pulses[k] = 0;
    for (int i = 0; i <= stop_y * 8 + stop_x; i++) begin
      y = i / 8;
      x = i % 8;
      if ($urandom_range(0, 99) < gap_pct) begin
        valid_in = 1'b0;
        sof_in   = 1'b0;
        pixel_in = 16'hdead;
        step();
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (vo[k] !== 1'b0 || fd[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_idle dut%0d pix(%0d,%0d): valid_out=%b frame_done=%b expected 0/0", k, y, x, vo[k], fd[k]);
          end
        end
      end
      valid_in = 1'b1;
      sof_in   = (i == 0);
      pixel_in = pix(base, y, x);
      step();
      valid_in = 1'b0;
      sof_in   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s        = s_of[k];
        exp_emit = (x >= 3) && (y >= 3) && ((x - 3) % s == 0) && ((y - 3) % s == 0);
        exp_fd   = (x == 7) && (y == 7);
        n_cmp++;
        if (vo[k] !== exp_emit) begin
          n_bad++;
          $display("FAIL valid_out dut%0d pix(%0d,%0d): got %b expected %b", k, y, x, vo[k], exp_emit);
        end
        n_cmp++;
        if (fd[k] !== exp_fd) begin
          n_bad++;
          $display("FAIL frame_done dut%0d pix(%0d,%0d): got %b expected %b", k, y, x, fd[k], exp_fd);
        end
        if (exp_emit) begin
          pulses[k]++;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) e[r][c] = pix(base, y - 3 + r, x - 3 + c);
          n_cmp++;
          if (po[k] !== e) begin
            n_bad++;
            $display("FAIL patch dut%0d pix(%0d,%0d): got %h expected %h", k, y, x, po[k], e);
          end
          n_cmp++;
          if (tx[k] !== 8'((x - 3) / s) || ty[k] !== 8'((y - 3) / s)) begin
            n_bad++;
            $display("FAIL tile dut%0d pix(%0d,%0d): got (%0d,%0d) expected (%0d,%0d)",
                     k, y, x, tx[k], ty[k], (x - 3) / s, (y - 3) / s);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    pixel_in = '0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      sof_in   = (i % 2 == 0);
      pixel_in = 16'h1234 + DW'(i);
      step();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (vo[k] !== 1'b0 || fd[k] !== 1'b0 || po[k] !== '0 || tx[k] !== 8'd0 || ty[k] !== 8'd0) begin
          n_bad++;
          $display("FAIL reset_hold dut%0d: vo=%b fd=%b tile=(%0d,%0d) patch=%h expected all 0",
                   k, vo[k], fd[k], tx[k], ty[k], po[k]);
        end
      end
    end
    valid_in = 1'b0;
    sof_in   = 1'b0;
    rst_n    = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    run_frame(0, 0, 7, 7);
    n_cmp++;
    if (pulses[0] != 9) begin
      n_bad++;
      $display("FAIL full_frame_count: got %0d expected 9", pulses[0]);
    end
    step();
    n_cmp++;
    if (vo[0] !== 1'b0 || po[0][0][0] !== 16'h0044 || po[0][3][3] !== 16'h0077 ||
        tx[0] !== 8'd2 || ty[0] !== 8'd2) begin
      n_bad++;
      $display("FAIL last_patch_hold: vo=%b p00=%h p33=%h tile=(%0d,%0d) expected 0/0044/0077/(2,2)",
               vo[0], po[0][0][0], po[0][3][3], tx[0], ty[0]);
    end
  endtask

  task automatic test_gaps();
    run_frame(16'h0300, 50, 7, 7);
    n_cmp++;
    if (pulses[0] != 9) begin
      n_bad++;
      $display("FAIL gaps_count: got %0d expected 9", pulses[0]);
    end
  endtask

  task automatic test_sof_handling();
    // Pixels without sof while idle must be ignored.
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      sof_in   = 1'b0;
      pixel_in = 16'h7fff;
      step();
      n_cmp++;
      if (vo[0] !== 1'b0 || fd[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_drop: vo=%b fd=%b expected 0/0", vo[0], fd[0]);
      end
    end
    valid_in = 1'b0;
    // Partial frame up to (5,1); the next sof lands where (5,2) would be.
    run_frame(16'h0100, 0, 5, 1);
    run_frame(16'h0500, 0, 7, 7);
    n_cmp++;
    if (pulses[0] != 9) begin
      n_bad++;
      $display("FAIL restart_count: got %0d expected 9", pulses[0]);
    end
  endtask

  task automatic test_strides();
    run_frame(16'h0700, 0, 7, 7);
    n_cmp++;
    if (pulses[1] != 25) begin
      n_bad++;
      $display("FAIL stride1_count: got %0d expected 25", pulses[1]);
    end
    n_cmp++;
    if (pulses[2] != 4) begin
      n_bad++;
      $display("FAIL stride3_count: got %0d expected 4", pulses[2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(16'h0900, 0, 4, 6);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (vo[k] !== 1'b0 || fd[k] !== 1'b0 || po[k] !== '0 || tx[k] !== 8'd0 || ty[k] !== 8'd0) begin
        n_bad++;
        $display("FAIL async_reset dut%0d: vo=%b fd=%b tile=(%0d,%0d) patch=%h expected all 0",
                 k, vo[k], fd[k], tx[k], ty[k], po[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_frame(16'h0a00, 0, 7, 7);
    n_cmp++;
    if (pulses[0] != 9 || pulses[1] != 25 || pulses[2] != 4) begin
      n_bad++;
      $display("FAIL post_reset_counts: got %0d/%0d/%0d expected 9/25/4", pulses[0], pulses[1], pulses[2]);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    pixel_in = '0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_gaps();
    test_sof_handling();
    test_strides();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
